// File: rtl/lsu_mem_ctrl_if.sv
// Request/response channel between the execute stage and the load/store unit.
// The master side is the execute stage and the slave side is the LSU.
interface lsu_mem_ctrl_if;
  logic        req_valid;
  logic        mem_load;
  logic        mem_store;
  logic [2:0]  funct3;
  logic [31:0] data_address;
  logic [31:0] read_value2;
  logic        req_ready;
  logic        done;
  logic [31:0] read_data;
  logic        misaligned;

  modport master (
    output req_valid, mem_load, mem_store, funct3, data_address, read_value2,
    input  req_ready, done, read_data, misaligned
  );

  modport slave (
    input  req_valid, mem_load, mem_store, funct3, data_address, read_value2,
    output req_ready, done, read_data, misaligned
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the RV32I execute stage and a synchronous data RAM.
// One request per accept; forms byte enables and lane-replicated write data,
// waits out the RAM read latency and returns the sign/zero-extended result.
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : misaligned accesses are trapped (no RAM access, done + misaligned)
//   undefined : misaligned tied low, low address bits masked to natural alignment
// Completion timing: no-op/trap -> done at T+1, store -> done at T+2,
// load -> done at T+2+RD_LATENCY (done is registered, so it shows up the cycle
// after ISSUE for stores and the cycle after RESP for loads).
module lsu_mem_ctrl #(
  parameter int RAM_AW     = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  lsu_mem_ctrl_if.slave     req,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Last WAIT count before the read data is valid (WAIT spans RD_LATENCY-1 cycles).
  localparam logic [1:0] WAIT_LAST = 2'((RD_LATENCY > 1) ? (RD_LATENCY - 2) : 0);

  state_t            state_reg, state_next;
  logic [1:0]        wait_cnt_reg, wait_cnt_next;
  logic [2:0]        funct3_reg;
  logic [1:0]        lane_reg;
  logic              is_load_reg;
  logic              done_reg, done_next;
  logic              misaligned_reg, misaligned_next;
  logic [31:0]       read_data_reg;
  logic              ram_en_reg;
  logic [3:0]        ram_we_reg;
  logic [RAM_AW-1:0] ram_addr_reg;
  logic [31:0]       ram_wdata_reg;

  logic        accept, do_load, do_store, do_access;
  logic        size_byte, size_half, size_word, trap;
  logic [1:0]  lane;
  logic [3:0]  we_dec;
  logic [31:0] wdata_dec;
  logic [31:0] load_result;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Upper address bits beyond the RAM are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req.data_address[31:RAM_AW+2];

  // Decode the incoming request: access type, size, lane, enables and write data.
  always_comb begin
    do_store  = req.mem_store;                   // store wins when both are set
    do_load   = req.mem_load & ~req.mem_store;
    do_access = do_store | do_load;
    accept    = req.req_valid & (state_reg == IDLE);
    if (do_store) begin
      size_byte = (req.funct3 == 3'b000);
      size_half = (req.funct3 == 3'b001);
    end else begin
      size_byte = (req.funct3[1:0] == 2'b00);    // LB / LBU
      size_half = (req.funct3[1:0] == 2'b01);    // LH / LHU
    end
    size_word = ~size_byte & ~size_half;         // SW/LW and all unlisted codes
    // Lane is masked to natural alignment; only matters when not trapping.
    if (size_byte)      lane = req.data_address[1:0];
    else if (size_half) lane = {req.data_address[1], 1'b0};
    else                lane = 2'b00;
    if (size_byte) begin
      we_dec    = 4'b0001 << lane;
      wdata_dec = {4{req.read_value2[7:0]}};
    end else if (size_half) begin
      we_dec    = 4'b0011 << lane;
      wdata_dec = {2{req.read_value2[15:0]}};
    end else begin
      we_dec    = 4'b1111;
      wdata_dec = req.read_value2;
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign trap = do_access & ((size_half & req.data_address[0]) |
                             (size_word & (req.data_address[1:0] != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  // Next-state logic and completion pulses.
  always_comb begin
    state_next      = state_reg;
    wait_cnt_next   = wait_cnt_reg;
    done_next       = 1'b0;
    misaligned_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (do_access && !trap) begin
            state_next = ISSUE;
          end else begin
            done_next       = 1'b1;              // no-op or trapped access
            misaligned_next = trap;
          end
        end
      end
      ISSUE: begin
        if (!is_load_reg) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else if (RD_LATENCY <= 1) begin
          state_next = RESP;
        end else begin
          state_next    = WAIT;
          wait_cnt_next = 2'd0;
        end
      end
      WAIT: begin
        if (wait_cnt_reg == WAIT_LAST) state_next = RESP;
        else                           wait_cnt_next = wait_cnt_reg + 2'd1;
      end
      RESP: begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Select and extend the addressed lane(s) of the returned RAM word.
  always_comb begin
    case (lane_reg)
      2'd0:    byte_sel = ram_rdata[7:0];
      2'd1:    byte_sel = ram_rdata[15:8];
      2'd2:    byte_sel = ram_rdata[23:16];
      default: byte_sel = ram_rdata[31:24];
    endcase
    half_sel = lane_reg[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (funct3_reg[1:0])
      2'b00:   load_result = funct3_reg[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_result = funct3_reg[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_result = ram_rdata;
    endcase
  end

  // FSM state, wait counter and completion flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      wait_cnt_reg   <= 2'd0;
      done_reg       <= 1'b0;
      misaligned_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wait_cnt_reg   <= wait_cnt_next;
      done_reg       <= done_next;
      misaligned_reg <= misaligned_next;
    end
  end

  // Latch the accepted request's attributes for the response path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      funct3_reg  <= 3'd0;
      lane_reg    <= 2'd0;
      is_load_reg <= 1'b0;
    end else if (accept) begin
      funct3_reg  <= req.funct3;
      lane_reg    <= lane;
      is_load_reg <= do_load;
    end
  end

  // Registered RAM interface: ram_en/ram_we pulse for the single ISSUE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_en_reg    <= 1'b0;
      ram_we_reg    <= 4'd0;
      ram_addr_reg  <= '0;
      ram_wdata_reg <= 32'd0;
    end else begin
      ram_en_reg <= 1'b0;
      ram_we_reg <= 4'd0;
      if (accept && do_access && !trap) begin
        ram_en_reg   <= 1'b1;
        ram_we_reg   <= do_store ? we_dec : 4'd0;
        ram_addr_reg <= req.data_address[RAM_AW+1:2];
        if (do_store) ram_wdata_reg <= wdata_dec;
      end
    end
  end

  // Load result register, updated only when a load completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 read_data_reg <= 32'd0;
    else if (state_reg == RESP) read_data_reg <= load_result;
  end

  assign req.req_ready  = (state_reg == IDLE);
  assign req.done       = done_reg;
  assign req.read_data  = read_data_reg;
  assign req.misaligned = misaligned_reg;
  assign ram_en         = ram_en_reg;
  assign ram_we         = ram_we_reg;
  assign ram_addr       = ram_addr_reg;
  assign ram_wdata      = ram_wdata_reg;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: one DUT with RD_LATENCY=1 for the main
// sequence and one with RD_LATENCY=2 for the latency/busy-ignore case.
module tb_lsu_mem_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl_if bus1 ();
  lsu_mem_ctrl_if bus2 ();

  logic        ram_en1, ram_en2;
  logic [3:0]  ram_we1, ram_we2;
  logic [9:0]  ram_addr1, ram_addr2;
  logic [31:0] ram_wdata1, ram_wdata2;
  logic [31:0] ram_rdata1, ram_rdata2, rd_stage2;
  logic [31:0] mem1 [0:1023];
  logic [31:0] mem2 [0:1023];

  lsu_mem_ctrl #(.RAM_AW(10), .RD_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req(bus1.slave),
    .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1),
    .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
  );

  lsu_mem_ctrl #(.RAM_AW(10), .RD_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .req(bus2.slave),
    .ram_en(ram_en2), .ram_we(ram_we2), .ram_addr(ram_addr2),
    .ram_wdata(ram_wdata2), .ram_rdata(ram_rdata2)
  );

  // Byte-writable RAM model, one cycle read latency.
  always @(posedge clk) begin
    if (ram_en1) begin
      for (int b = 0; b < 4; b++)
        if (ram_we1[b]) mem1[ram_addr1][b*8 +: 8] <= ram_wdata1[b*8 +: 8];
      if (ram_we1 == 4'd0) ram_rdata1 <= mem1[ram_addr1];
    end
  end

  // Byte-writable RAM model, two cycle read latency.
  always @(posedge clk) begin
    if (ram_en2) begin
      for (int b = 0; b < 4; b++)
        if (ram_we2[b]) mem2[ram_addr2][b*8 +: 8] <= ram_wdata2[b*8 +: 8];
      if (ram_we2 == 4'd0) rd_stage2 <= mem2[ram_addr2];
    end
    ram_rdata2 <= rd_stage2;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive1(logic ld, logic st, logic [2:0] f3, logic [31:0] addr, logic [31:0] rs2);
    bus1.req_valid    = 1'b1;
    bus1.mem_load     = ld;
    bus1.mem_store    = st;
    bus1.funct3       = f3;
    bus1.data_address = addr;
    bus1.read_value2  = rs2;
  endtask

  task automatic idle1();
    bus1.req_valid = 1'b0;
    bus1.mem_load  = 1'b0;
    bus1.mem_store = 1'b0;
  endtask

  task automatic do_store(string tag, logic both, logic [2:0] f3, logic [31:0] addr,
                          logic [31:0] rs2, logic [3:0] we, logic [31:0] wdata, logic [9:0] waddr);
    check({tag, ".ready"}, bus1.req_ready, 1);
    drive1(both, 1'b1, f3, addr, rs2);
    tick();                                   // T+1
    idle1();
    check({tag, ".en"}, ram_en1, 1);
    check({tag, ".we"}, ram_we1, we);
    check({tag, ".addr"}, ram_addr1, waddr);
    check({tag, ".wdata"}, ram_wdata1, wdata);
    check({tag, ".done_t1"}, bus1.done, 0);
    tick();                                   // T+2
    check({tag, ".done_t2"}, bus1.done, 1);
    check({tag, ".en_t2"}, ram_en1, 0);
    tick();
    check({tag, ".done_t3"}, bus1.done, 0);
    $display("[TB] store %s addr=0x%08h rs2=0x%08h we=%b", tag, addr, rs2, we);
  endtask

  task automatic do_load(string tag, logic [2:0] f3, logic [31:0] addr,
                         logic [9:0] waddr, logic [31:0] exp_data);
    check({tag, ".ready"}, bus1.req_ready, 1);
    drive1(1'b1, 1'b0, f3, addr, 32'd0);
    tick();                                   // T+1
    idle1();
    check({tag, ".en"}, ram_en1, 1);
    check({tag, ".we"}, ram_we1, 0);
    check({tag, ".addr"}, ram_addr1, waddr);
    tick();                                   // T+2
    check({tag, ".done_t2"}, bus1.done, 0);
    tick();                                   // T+3
    check({tag, ".done_t3"}, bus1.done, 1);
    check({tag, ".data"}, bus1.read_data, exp_data);
    check({tag, ".mis"}, bus1.misaligned, 0);
    tick();
    check({tag, ".done_t4"}, bus1.done, 0);
    $display("[TB] load %s addr=0x%08h f3=%b data=0x%08h", tag, addr, f3, bus1.read_data);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem1[i] = 32'd0;
      mem2[i] = 32'd0;
    end
    ram_rdata1 = 32'd0;
    ram_rdata2 = 32'd0;
    rd_stage2  = 32'd0;
    idle1();
    bus1.funct3 = 3'd0; bus1.data_address = 32'd0; bus1.read_value2 = 32'd0;
    bus2.req_valid = 1'b0; bus2.mem_load = 1'b0; bus2.mem_store = 1'b0;
    bus2.funct3 = 3'd0; bus2.data_address = 32'd0; bus2.read_value2 = 32'd0;

    // Reset state
    tick(); tick();
    check("rst.ready", bus1.req_ready, 1);
    check("rst.done", bus1.done, 0);
    check("rst.en", ram_en1, 0);
    check("rst.we", ram_we1, 0);
    check("rst.addr", ram_addr1, 0);
    check("rst.wdata", ram_wdata1, 0);
    check("rst.rdata", bus1.read_data, 0);
    check("rst.mis", bus1.misaligned, 0);
    reset = 1'b1;
    tick();

    // Word, byte and half accesses
    do_store("sw10", 1'b0, 3'b010, 32'h10, 32'h12345678, 4'b1111, 32'h12345678, 10'd4);
    do_load("lw10", 3'b010, 32'h10, 10'd4, 32'h12345678);
    do_store("sb13", 1'b0, 3'b000, 32'h13, 32'h123456AB, 4'b1000, 32'hABABABAB, 10'd4);
    do_load("lb13", 3'b000, 32'h13, 10'd4, 32'hFFFFFFAB);
    do_load("lbu13", 3'b100, 32'h13, 10'd4, 32'h000000AB);
    do_load("lb12", 3'b000, 32'h12, 10'd4, 32'h00000034);
    do_store("sh22", 1'b0, 3'b001, 32'h22, 32'h5A5A8001, 4'b1100, 32'h80018001, 10'd8);
    do_load("lh22", 3'b001, 32'h22, 10'd8, 32'hFFFF8001);
    do_load("lhu22", 3'b101, 32'h22, 10'd8, 32'h00008001);
    do_load("lh20", 3'b001, 32'h20, 10'd8, 32'h00000000);

    // Request with neither load nor store: no RAM access, done at T+1
    drive1(1'b0, 1'b0, 3'b010, 32'h10, 32'd0);
    tick();
    idle1();
    check("noop.done", bus1.done, 1);
    check("noop.en", ram_en1, 0);
    check("noop.ready", bus1.req_ready, 1);
    tick();
    check("noop.done_off", bus1.done, 0);
    $display("[TB] noop");

    // Load and store both high: store only
    do_store("both30", 1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 10'd12);
    do_load("lw30", 3'b010, 32'h30, 10'd12, 32'hCAFEF00D);

    // Misaligned word load
    do_store("sw04", 1'b0, 3'b010, 32'h04, 32'h11223344, 4'b1111, 32'h11223344, 10'd1);
`ifdef MISALIGN_TRAP_EN
    drive1(1'b1, 1'b0, 3'b010, 32'h06, 32'd0);
    tick();
    idle1();
    check("mis06.en", ram_en1, 0);
    check("mis06.done", bus1.done, 1);
    check("mis06.mis", bus1.misaligned, 1);
    check("mis06.rdata", bus1.read_data, 32'hCAFEF00D);
    tick();
    check("mis06.done_off", bus1.done, 0);
    check("mis06.mis_off", bus1.misaligned, 0);
    $display("[TB] trap lw06");
`else
    do_load("lw06", 3'b010, 32'h06, 10'd1, 32'h11223344);
`endif

    // RD_LATENCY=2: store then load with req_valid held T..T+3
    bus2.req_valid = 1'b1; bus2.mem_store = 1'b1; bus2.funct3 = 3'b010;
    bus2.data_address = 32'h40; bus2.read_value2 = 32'h0BADBEEF;
    tick();
    bus2.req_valid = 1'b0; bus2.mem_store = 1'b0;
    check("l2sw.en", ram_en2, 1);
    tick();
    check("l2sw.done", bus2.done, 1);
    tick();
    bus2.req_valid = 1'b1; bus2.mem_load = 1'b1;
    tick();                                   // T+1
    check("l2lw.en_t1", ram_en2, 1);
    check("l2lw.addr", ram_addr2, 10'd16);
    tick();                                   // T+2
    check("l2lw.en_t2", ram_en2, 0);
    check("l2lw.done_t2", bus2.done, 0);
    tick();                                   // T+3
    check("l2lw.en_t3", ram_en2, 0);
    check("l2lw.done_t3", bus2.done, 0);
    tick();                                   // T+4
    bus2.req_valid = 1'b0; bus2.mem_load = 1'b0;
    check("l2lw.done_t4", bus2.done, 1);
    check("l2lw.data", bus2.read_data, 32'h0BADBEEF);
    tick();                                   // T+5
    check("l2lw.done_t5", bus2.done, 0);
    check("l2lw.en_t5", ram_en2, 0);
    check("l2lw.ready_t5", bus2.req_ready, 1);
    $display("[TB] lat2 load data=0x%08h", bus2.read_data);

    // Reset asserted at T+1 of a load
    drive1(1'b1, 1'b0, 3'b010, 32'h10, 32'd0);
    tick();
    idle1();
    check("rstmid.en_before", ram_en1, 1);
    #2 reset = 1'b0;
    #1;
    check("rstmid.en", ram_en1, 0);
    check("rstmid.we", ram_we1, 0);
    check("rstmid.ready", bus1.req_ready, 1);
    check("rstmid.rdata", bus1.read_data, 0);
    tick();
    check("rstmid.done_a", bus1.done, 0);
    tick();
    check("rstmid.done_b", bus1.done, 0);
    reset = 1'b1;
    tick();
    check("rstmid.done_c", bus1.done, 0);
    check("rstmid.ready_c", bus1.req_ready, 1);
    check("rstmid.en_c", ram_en1, 0);
    $display("[TB] reset during load");
    do_store("sw50", 1'b0, 3'b010, 32'h50, 32'hA5A55A5A, 4'b1111, 32'hA5A55A5A, 10'd20);
    do_load("lw50", 3'b010, 32'h50, 10'd20, 32'hA5A55A5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
